// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and sizing helpers for the parallel-to-serial stream converter.
package p2s_pkg;
  typedef enum logic {P2S_IDLE, P2S_SHIFT} p2s_state_e;
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction
  function automatic int cnt_width(input int fl);
    return fl > 2 ? $clog2(fl) : 1;
  endfunction
endpackage

// File: rtl/p2s_parity_calc.sv
// p2s_parity_calc: parity of a word with selectable sense; only built when P2S_PARITY_EN is defined.
`ifdef P2S_PARITY_EN
module p2s_parity_calc #(
  parameter int WIDTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic [WIDTH-1:0] d,
  output logic             parity
);
  assign parity = ^d ^ 1'(PARITY_ODD);
endmodule
`endif

// File: rtl/par2ser_stream.sv
// par2ser_stream: valid/ready word in, framed serial bit out with last marker and abort.
// Optional trailing parity bit enabled by defining P2S_PARITY_EN.
module par2ser_stream
  import p2s_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             dout,
  output logic             valid_out,
  output logic             last_out
);
`ifdef P2S_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = frame_len(WIDTH, PAR_EN);
  localparam int CNT_W = cnt_width(FL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FL - 1);
  if (WIDTH < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("par2ser_stream: WIDTH must be >=2 and PARITY_ODD 0 or 1");
  end
  p2s_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ord;
  logic [FL-1:0] frame, sr;
  logic busy, at_last, accept;
  // ord holds the word in transmission order, first bit at the MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_ord
    assign ord[i] = MSB_FIRST ? d[i] : d[WIDTH-1-i];
  end
`ifdef P2S_PARITY_EN
  logic par;
  p2s_parity_calc #(.WIDTH(WIDTH), .PARITY_ODD(PARITY_ODD)) u_par (.d(d), .parity(par));
  assign frame = {ord, par};
`else
  assign frame = ord;
`endif
  assign busy     = state == P2S_SHIFT;
  assign at_last  = busy && cnt == LAST;
  assign in_ready = rst_n && (!busy || at_last);
  assign accept   = in_valid && in_ready && !abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= P2S_IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = abort                ? P2S_IDLE  :
                accept               ? P2S_SHIFT :
                (busy && !at_last)   ? P2S_SHIFT : P2S_IDLE;
  always_comb begin
    valid_out = busy;
    last_out  = at_last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      sr   <= '0;
      dout <= IDLE_LEVEL;
    end else if (abort) begin
      cnt  <= '0;
      dout <= IDLE_LEVEL;
    end else if (accept) begin
      cnt  <= '0;
      dout <= frame[FL-1];
      sr   <= frame << 1;
    end else if (busy && !at_last) begin
      cnt  <= cnt + 1'b1;
      dout <= sr[FL-1];
      sr   <= sr << 1;
    end else begin
      cnt  <= '0;
      dout <= IDLE_LEVEL;
    end
endmodule

// File: tb/tb_par2ser_stream.sv
// tb_par2ser_stream: directed + random stimulus against a queue-based frame model, two DUT configurations.
module tb_par2ser_stream;
  localparam int W = 4;
`ifdef P2S_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int FL = PEN ? W + 1 : W;
  typedef struct {bit b; bit last;} ebit_t;
  logic clk = 0, rst_n = 1, in_valid = 0, abort = 0;
  logic [W-1:0] d = '0;
  logic rdy0, rdy1, dout0, dout1, v0, v1, l0, l1;
  int checks = 0, errors = 0;
  ebit_t q [2][$];
  bit msb_a [2] = '{1'b1, 1'b0};
  bit idle_a [2] = '{1'b0, 1'b1};
  bit odd_a [2] = '{1'b0, 1'b1};
  always #5 clk = ~clk;
  par2ser_stream #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .d(d), .in_valid(in_valid), .in_ready(rdy0), .abort(abort),
    .dout(dout0), .valid_out(v0), .last_out(l0));
  par2ser_stream #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .d(d), .in_valid(in_valid), .in_ready(rdy1), .abort(abort),
    .dout(dout1), .valid_out(v1), .last_out(l1));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic eb, ev, el;
      ev = q[k].size() != 0;
      eb = ev ? q[k][0].b : idle_a[k];
      el = ev ? q[k][0].last : 1'b0;
      chk($sformatf("%s_u%0d_dout", tag, k), k ? dout1 : dout0, eb);
      chk($sformatf("%s_u%0d_valid", tag, k), k ? v1 : v0, ev);
      chk($sformatf("%s_u%0d_last", tag, k), k ? l1 : l0, el);
    end
  endtask
  task automatic check_ready(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s_u%0d_ready", tag, k), k ? rdy1 : rdy0, rst_n && q[k].size() <= 1);
  endtask
  task automatic push_frame(input int k, input logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      q[k].push_back('{msb_a[k] ? w[W-1-i] : w[i], i == FL - 1});
    if (PEN) q[k].push_back('{(^w) ^ odd_a[k], 1'b1});
  endtask
  // drive one cycle of inputs, check ready, advance model and check outputs after the edge
  task automatic cycle(input logic [W-1:0] dd, input logic vv, input logic ab, input string tag,
                       output bit acc);
    bit a [2];
    d = dd; in_valid = vv; abort = ab;
    #1;
    check_ready(tag);
    for (int k = 0; k < 2; k++) a[k] = vv && q[k].size() <= 1 && !ab;
    acc = a[0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ab) q[k].delete();
      else begin
        if (q[k].size() != 0) void'(q[k].pop_front());
        if (a[k]) push_frame(k, dd);
      end
    end
    #1;
    check_outs(tag);
  endtask
  initial begin
    bit acc;
    logic [W-1:0] words [$];
    logic [2*FL-1:0] seq, exp_seq;
    logic [FL-1:0] seq0, exp0;
    #2 rst_n = 0;
    #2 check_outs("reset");
    check_ready("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_outs("idle");
    cycle('0, 0, 0, "idle2", acc);
    // single word 1011
    seq0 = '0;
    cycle(4'b1011, 1, 0, "single_acc", acc);
    chk("single_accepted", acc, 1'b1);
    if (v0) seq0 = {seq0[FL-2:0], dout0};
    for (int i = 0; i < FL + 1; i++) begin
      cycle('0, 0, 0, "single", acc);
      if (v0) seq0 = {seq0[FL-2:0], dout0};
    end
`ifdef P2S_PARITY_EN
    exp0 = 5'b10111;
`else
    exp0 = 4'b1011;
`endif
    chk("single_seq", 16'(seq0), 16'(exp0));
    // back-to-back A then 5, observed on the LSB-first instance
    words = '{4'hA, 4'h5};
    seq = '0;
    for (int i = 0; i < 4 * FL && (words.size() != 0 || v1); i++) begin
      logic [W-1:0] w;
      w = words.size() != 0 ? words[0] : W'($urandom);
      cycle(w, words.size() != 0, 0, "b2b", acc);
      if (acc) void'(words.pop_front());
      if (v1) seq = {seq[2*FL-2:0], dout1};
    end
    chk("b2b_words_left", 16'(words.size()), 16'd0);
`ifdef P2S_PARITY_EN
    exp_seq = 10'b0101110101;
`else
    exp_seq = 8'b01011010;
`endif
    chk("b2b_seq", 16'(seq), 16'(exp_seq));
    // abort while bit 2 of 4'hF is on the line, then a full word
    cycle(4'hF, 1, 0, "abort_acc", acc);
    cycle('0, 0, 0, "abort_b1", acc);
    cycle('0, 0, 0, "abort_b2", acc);
    cycle(4'h3, 1, 1, "abort", acc);
    chk("abort_masks_accept", acc, 1'b0);
    cycle(4'h6, 1, 0, "post_abort", acc);
    for (int i = 0; i < FL + 1; i++) cycle('0, 0, 0, "post_abort", acc);
    // async reset mid-frame
    cycle(4'h9, 1, 0, "arst_acc", acc);
    cycle('0, 0, 0, "arst_b1", acc);
    #2 rst_n = 0;
    for (int k = 0; k < 2; k++) q[k].delete();
    #1 check_outs("arst_now");
    check_ready("arst_now");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle('0, 0, 0, "arst_after", acc);
    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(W'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand", acc);
    for (int i = 0; i < FL + 1; i++) cycle('0, 0, 0, "drain", acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
